// File: rtl/eq_chk_pkg.sv
// eq_chk_pkg: shared types and constants for the output equivalence checker.
// Holds the FSM state type, default widths and the cycle-counter ceiling.
package eq_chk_pkg;

    typedef enum logic [1:0] {
        S_WARMUP = 2'd0,
        S_CHECK  = 2'd1,
        S_FAIL   = 2'd2
    } eq_state_t;

    localparam int DEF_W      = 8;
    localparam int DEF_WARMUP = 3;
    localparam int DEF_CNT_W  = 8;
    localparam int CYC_W      = 16;

    localparam logic [CYC_W-1:0] CYC_MAX = 16'hFFFF;

endpackage

// File: rtl/eq_sat_cnt.sv
// eq_sat_cnt: up-counter with enable and synchronous clear.
// Holds at all-ones instead of wrapping.
module eq_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX = '1;

    // clear wins; otherwise count up until all-ones
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (inc && (q != MAX)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/eq_out_checker.sv
// eq_out_checker: compares an aligned spec output against the implementation.
// Define EQ_CHK_CYCLE_EN to add a cycle counter and record first_cyc.
module eq_out_checker
    import eq_chk_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int WARMUP = DEF_WARMUP,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [W-1:0]     s_out,
    input  logic [W-1:0]     i_out,
    output logic             mismatch,
    output logic             fail,
    output logic [CNT_W-1:0] err_cnt,
    output logic [W-1:0]     first_s,
    output logic [W-1:0]     first_i,
    output logic [15:0]      first_cyc,
    output logic [1:0]       state
);

    localparam int WC_W = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
    localparam int LAST = (WARMUP < 1) ? 0 : WARMUP - 1;
    localparam logic [WC_W-1:0] WARM_LAST = WC_W'(LAST);

    // with no warm-up the checker starts comparing straight out of reset
    localparam eq_state_t RST_ST = (WARMUP == 0) ? S_CHECK : S_WARMUP;

    eq_state_t       st;
    logic [WC_W-1:0] warm_cnt;
    logic            warm_inc;
    logic            warm_done;
    logic            cmp;
    logic            miss;

    assign warm_inc  = en && (st == S_WARMUP);
    assign warm_done = (WARMUP == 0) || (warm_cnt == WARM_LAST);
    assign cmp       = en && ((st == S_CHECK) || (st == S_FAIL));
    assign miss      = cmp && (s_out != i_out);
    assign state     = st;

    eq_sat_cnt #(.W(WC_W)) u_warm (
        .clk (clk),
        .clr (reset),
        .inc (warm_inc),
        .q   (warm_cnt)
    );

    eq_sat_cnt #(.W(CNT_W)) u_err (
        .clk (clk),
        .clr (reset),
        .inc (miss),
        .q   (err_cnt)
    );

`ifdef EQ_CHK_CYCLE_EN
    logic [CYC_W-1:0] cyc;
    logic [CYC_W-1:0] first_cyc_q;

    eq_sat_cnt #(.W(CYC_W)) u_cyc (
        .clk (clk),
        .clr (reset),
        .inc (1'b1),
        .q   (cyc)
    );

    assign first_cyc = first_cyc_q;
`else
    assign first_cyc = '0;
`endif

    // FSM plus registered flags and first-mismatch captures
    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= RST_ST;
            mismatch <= 1'b0;
            fail     <= 1'b0;
            first_s  <= '0;
            first_i  <= '0;
`ifdef EQ_CHK_CYCLE_EN
            first_cyc_q <= '0;
`endif
        end else begin
            mismatch <= miss;
            case (st)
                S_WARMUP: begin
                    if (en && warm_done) begin
                        st <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (miss) begin
                        st      <= S_FAIL;
                        fail    <= 1'b1;
                        first_s <= s_out;
                        first_i <= i_out;
`ifdef EQ_CHK_CYCLE_EN
                        first_cyc_q <= cyc;
`endif
                    end
                end
                S_FAIL: begin
                    st <= S_FAIL;
                end
                default: begin
                    st <= S_WARMUP;
                end
            endcase
        end
    end

endmodule
